// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end for the bit-stream sequence detectors.
//   Accepts DATA_W-bit words on a valid/ready handshake and emits them
//   MSB-first, one bit per clock, with first/last frame strobes.
//
//   Optional feature macro: BIT_SERIALIZER_SKID_EN
//     When defined, a one-word holding register is added so that frames
//     can be sent back to back with no idle cycle in between.
//
// Parameters
//   DATA_W      word width in bits (>= 2)
//   IDLE_LEVEL  level driven on ser_out while ser_valid is 0
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   par_in     in   parallel word, captured on an accepting edge
//   par_valid  in   upstream offers a word
//   par_ready  out  a word can be accepted this cycle (combinational)
//   ser_out    out  serial data bit (registered)
//   ser_valid  out  ser_out carries a data bit (registered)
//   ser_first  out  current bit is the word MSB (registered)
//   ser_last   out  current bit is the word LSB (registered)
//   busy       out  ser_valid or holding register occupied
// ---------------------------------------------------------------------------
module bit_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] par_in,
  input  logic              par_valid,
  output logic              par_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  localparam int unsigned       CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ser_valid;
  logic                r_ser_first;
  logic                r_ser_last;

  logic                w_accept;
  logic                w_free;
  logic                w_load;
  logic [DATA_W-1:0]   w_load_word;

  // Shifter can take a new word when idle or while its last bit is on the line
  assign w_free   = (r_state == ST_IDLE) || (r_cnt == '0);
  assign w_accept = par_valid && par_ready;

`ifdef BIT_SERIALIZER_SKID_EN
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;

  assign par_ready   = !r_hold_full && rst_n;
  assign busy        = r_ser_valid || r_hold_full;
  // A held word always takes priority; par_ready is low whenever hold is full
  assign w_load      = w_free && (r_hold_full || w_accept);
  assign w_load_word = r_hold_full ? r_hold : par_in;
`else
  assign par_ready   = (r_state == ST_IDLE) && rst_n;
  assign busy        = r_ser_valid;
  assign w_load      = w_free && w_accept;
  assign w_load_word = par_in;
`endif

  // MSB of the shift register is the line; idle refills keep it at IDLE_LEVEL
  assign ser_out   = r_shift[DATA_W-1];
  assign ser_valid = r_ser_valid;
  assign ser_first = r_ser_first;
  assign ser_last  = r_ser_last;

  // State, shifter, counter and strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= {DATA_W{IDLE_LEVEL}};
      r_cnt       <= '0;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      if (w_load) begin
        r_state     <= ST_SHIFT;
        r_shift     <= w_load_word;
        r_cnt       <= CNT_TOP;
        r_ser_valid <= 1'b1;
        r_ser_first <= 1'b1;
        r_ser_last  <= 1'b0;
      end else if (w_free) begin
        r_state     <= ST_IDLE;
        r_shift     <= {DATA_W{IDLE_LEVEL}};
        r_cnt       <= '0;
        r_ser_valid <= 1'b0;
        r_ser_first <= 1'b0;
        r_ser_last  <= 1'b0;
      end else begin
        r_shift     <= {r_shift[DATA_W-2:0], IDLE_LEVEL};
        r_cnt       <= r_cnt - CNT_ONE;
        r_ser_first <= 1'b0;
        // Flag the bit for which the counter reaches zero
        r_ser_last  <= (r_cnt == CNT_ONE);
      end
    end
  end

`ifdef BIT_SERIALIZER_SKID_EN
  // Holding register: filled when a word arrives while the shifter is busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept && !w_free) begin
      r_hold      <= par_in;
      r_hold_full <= 1'b1;
    end else if (w_free && r_hold_full) begin
      r_hold_full <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//   Self-checking bench for bit_serializer. A word-level reference model
//   (bit position within the current word plus a queue of waiting words)
//   predicts every output each cycle; frames reassembled from the line are
//   also compared with the words that were handed over. A second instance
//   with IDLE_LEVEL=1 is kept idle to check the idle line level.
//   Follows BIT_SERIALIZER_SKID_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int unsigned DATA_W = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [DATA_W-1:0] par_in    = '0;
  logic              par_valid = 1'b0;

  logic par_ready, ser_out, ser_valid, ser_first, ser_last, busy;
  logic hi_ready, hi_out, hi_valid, hi_first, hi_last, hi_busy;

  bit_serializer #(.DATA_W(DATA_W), .IDLE_LEVEL(1'b0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .par_in    (par_in),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  bit_serializer #(.DATA_W(DATA_W), .IDLE_LEVEL(1'b1)) u_dut_hi (
    .clk       (clk),
    .rst_n     (rst_n),
    .par_in    (par_in),
    .par_valid (1'b0),
    .par_ready (hi_ready),
    .ser_out   (hi_out),
    .ser_valid (hi_valid),
    .ser_first (hi_first),
    .ser_last  (hi_last),
    .busy      (hi_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int                m_pos = -1;      // index of bit on the line, -1 when idle
  logic [DATA_W-1:0] m_cur = '0;
  logic [DATA_W-1:0] m_hold[$];
  bit                m_acc = 1'b0;    // a word was taken at the last edge

  function automatic bit m_ready();
`ifdef BIT_SERIALIZER_SKID_EN
    return (rst_n === 1'b1) && (m_hold.size() == 0);
`else
    return (rst_n === 1'b1) && (m_pos < 0);
`endif
  endfunction

  always @(posedge clk) begin
    bit rdy;
    bit free;
    rdy   = m_ready();
    m_acc = (par_valid === 1'b1) && rdy;
    if (rst_n !== 1'b1) begin
      m_pos = -1;
      m_hold.delete();
      m_acc = 1'b0;
    end else begin
      free = (m_pos < 0) || (m_pos == DATA_W - 1);
      if (free) begin
        if (m_hold.size() > 0) begin
          m_cur = m_hold.pop_front();
          m_pos = 0;
        end else if (m_acc) begin
          m_cur = par_in;
          m_pos = 0;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
        if (m_acc) m_hold.push_back(par_in);
      end
    end
  end

  // ---------------- per-cycle output comparison ----------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    bit e_valid;
    bit e_out;
    if (chk_en) begin
      e_valid = (m_pos >= 0);
      e_out   = e_valid ? m_cur[DATA_W-1-m_pos] : 1'b0;
      check_val("ser_valid", 32'(ser_valid), 32'(e_valid));
      check_val("ser_out",   32'(ser_out),   32'(e_out));
      check_val("ser_first", 32'(ser_first), 32'(m_pos == 0));
      check_val("ser_last",  32'(ser_last),  32'(m_pos == DATA_W - 1));
      check_val("busy",      32'(busy),      32'(e_valid || (m_hold.size() > 0)));
      check_val("par_ready", 32'(par_ready), 32'(m_ready()));
      check_val("hi_idle_out",   32'(hi_out),   32'(1));
      check_val("hi_idle_valid", 32'(hi_valid), 32'(0));
    end
  end

  // ---------------- frame collector ----------------
  logic [DATA_W-1:0] col   = '0;
  int                col_n = 0;
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      col_n = 0;
    end else if (ser_valid === 1'b1) begin
      if (ser_first === 1'b1) col_n = 0;
      col = {col[DATA_W-2:0], ser_out};
      col_n++;
      if (ser_last === 1'b1) begin
        if (chk_en) check_val("frame_len", 32'(col_n), 32'(DATA_W));
        got_q.push_back(col);
        col_n = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DATA_W-1:0] w);
    bit done;
    done      = 1'b0;
    par_in    = w;
    par_valid = 1'b1;
    for (int c = 0; c < 4 * DATA_W + 8 && !done; c++) begin
      @(posedge clk);
      #1;
      if (m_acc) done = 1'b1;
    end
    if (done) exp_q.push_back(w);
    else      check_val("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle_cycles(input int n);
    par_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string tag);
    idle_cycles(3 * DATA_W);
    check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_val(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DATA_W-1:0] a5;
    a5 = 8'hA5;

    // Reset for two edges; the model checks everything low meanwhile
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(3);

    // Single word, bits checked against the literal pattern as well
    send(a5);
    par_valid = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      @(negedge clk);
      check_val("a5_bit",   32'(ser_out),   32'(a5[DATA_W-1-i]));
      check_val("a5_valid", 32'(ser_valid), 32'(1));
    end
    @(negedge clk);
    check_val("a5_gap_valid", 32'(ser_valid), 32'(0));
    check_val("a5_gap_out",   32'(ser_out),   32'(0));
    drain_check("a5_word");

    // Back to back with par_valid held high
    send(8'h99);
    send(8'h90);
    par_valid = 1'b0;
    drain_check("b2b_word");

    // Backpressure: 3C offered while the shifter is still busy
    send(8'h11);
    send(8'h3C);
    par_valid = 1'b0;
    drain_check("bp_word");

    // Mid-frame reset after three bits of FF
    send(8'hFF);
    par_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_mid_valid_pre", 32'(ser_valid), 32'(1));
    @(negedge clk);
    check_val("rst_mid_valid", 32'(ser_valid), 32'(0));
    check_val("rst_mid_ready", 32'(par_ready), 32'(0));
    #1 rst_n = 1'b1;
    idle_cycles(2 * DATA_W);
    check_val("rst_trunc_frames", 32'(got_q.size()), 32'(0));
    got_q.delete();
    exp_q.delete();

    // Idle line for 20 cycles
    idle_cycles(20);

    // Randomized words with random gaps
    for (int i = 0; i < 60; i++) begin
      send(DATA_W'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 10)));
    end
    par_valid = 1'b0;
    drain_check("rand_word");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detectors (e.g. the 1001 detector). Accepts `DATA_W`-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a serial line. That line connects directly to the detector's `data_in`. Side-band strobes mark frame boundaries so the bench or a downstream checker can align detector hits to word positions.

## Interface
- `DATA_W`, 8: word width in bits; legal range ≥ 2.
- `IDLE_LEVEL`, 1'b0: value driven on `ser_out` whenever `ser_valid` is 0.

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `par_in`  in  DATA_W  parallel word; sampled only on an accepting edge.
- `par_valid`  in  1  upstream has a word on `par_in`.
- `par_ready`  out  1  block can accept a word this cycle (combinational from state).
- `ser_out`  out  1  serial bit to downstream `data_in` (registered).
- `ser_valid`  out  1  `ser_out` carries a data bit this cycle (registered).
- `ser_first`  out  1  current bit is bit `DATA_W-1` of a word (registered).
- `ser_last`  out  1  current bit is bit 0 of a word (registered).
- `busy`  out  1  `ser_valid` OR holding register occupied.

## Operation
- Accept: rising edge with `par_valid && par_ready`. `par_in` is captured. A word not accepted must be held stable by upstream.
- States:
  - IDLE: shifter empty.
  - SHIFT: shifter emitting. Internal down-counter `cnt` (width `$clog2(DATA_W)`) indexes remaining bits.
- IDLE → SHIFT on accept:
  - shift register loads `par_in`; `cnt` ← `DATA_W-1`.
  - Outputs next cycle: `ser_out`=`par_in[DATA_W-1]`, `ser_valid`=1, `ser_first`=1.
- SHIFT, `cnt`≠0: shift left one bit; `ser_out` ← next MSB; `cnt` decrements.
  - `ser_last`=1 is registered together with the bit for which `cnt` becomes 0.
- SHIFT, `cnt`=0 (last bit on the line): shifter is "free" at this edge.
  - Next word available (holding reg, skid build only): reload, stay SHIFT, `ser_first`=1.
  - Otherwise: → IDLE; `ser_valid`=0, `ser_out`=`IDLE_LEVEL`, strobes 0.
- Base build `par_ready` = (state==IDLE) && `rst_n`.
- Reset (`rst_n`=0 at an edge):
  - State → IDLE; holding register emptied.
  - `ser_out`=`IDLE_LEVEL`; `ser_valid`, `ser_first`, `ser_last`, `busy`=0.
  - `par_ready` forced 0 while `rst_n`=0.
  - A mid-frame reset truncates the word; no remaining bits are ever emitted.
- Shift path uses no arithmetic except the counter decrement. The counter never wraps below 0.

## Timing
- Latency: word accepted at edge k → first bit valid in the cycle after edge k. Bit `i` appears after edge k+(`DATA_W-1-i`).
- `ser_last` in the cycle after edge k+`DATA_W`-1.
- Base build throughput: one word per `DATA_W`+1 cycles, with exactly one `ser_valid`=0 gap cycle between words. The next accept occurs at the gap-cycle edge at the earliest.
- `ser_first` and `ser_last` are never both 1 (`DATA_W`≥2).

## Configuration
- `BIT_SERIALIZER_SKID_EN`: adds a one-word holding register.
  - `par_ready` = !hold_full && `rst_n`.
  - Accepted word goes straight to the shifter if the shifter is free at that edge and hold is empty; otherwise it goes to hold.
  - Free shifter with hold full: loads from hold at that edge and hold empties. No accept that edge, since `par_ready` was 0.
  - Result: gapless back-to-back frames; continuous `par_valid` gives `DATA_W` bits per word with no idle cycles.
- Undefined: base behaviour above; hold logic absent; `busy` = `ser_valid`.

## Test plan
- Reset behaviour: `rst_n`=0 for 2 edges.
  - During reset: `ser_out`=0, `ser_valid`/`ser_first`/`ser_last`/`busy`/`par_ready`=0.
  - After release: `par_ready`=1 and the line idles at 0.
- Single word: `par_in`=8'hA5 accepted at edge k.
  - Cycles k+1..k+8: `ser_out` = 1,0,1,0,0,1,0,1 with `ser_valid`=1.
  - `ser_first` only at k+1, `ser_last` only at k+8.
  - Cycle k+9: `ser_valid`=0, `ser_out`=0.
- Back-to-back 8'h99 then 8'h90, `par_valid` held high:
  - Base build: one `ser_valid`=0 gap between words; `par_ready`=1 only in IDLE.
  - Skid build: 16 contiguous bits 1001100110010000; `par_ready` drops after the second accept. The downstream 1001 detector sees 3 hits.
- Mid-frame reset: 8'hFF accepted, `rst_n`=0 after 3 bits emitted.
  - Next cycle: `ser_valid`=0; hold cleared (skid build).
  - After release: no residual bits appear.
- Backpressure: `par_valid` asserted with 8'h3C while SHIFT (base build).
  - Not accepted until IDLE.
  - Word emitted exactly once, intact (0,0,1,1,1,1,0,0).
- Idle line: `par_valid`=0 for 20 cycles → `ser_out` constant `IDLE_LEVEL`. Repeat with `IDLE_LEVEL`=1 → constant 1, `ser_valid`=0.
